// File: rtl/rca_serial_n.sv
// rca_serial_n -- digit-serial ripple-carry adder.
//
// Adds two WIDTH-bit operands DIGIT bits per clock. The carry between digits
// is held in a register. Operands are captured on the input handshake, so
// the inputs are free to change while the sum is being built. The result is
// held until the output handshake completes.
//
// Parameters:
//   WIDTH  operand and sum width in bits (default 16)
//   DIGIT  bits added per clock; WIDTH must be a multiple of DIGIT (default 4)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_valid   in   A, B, Cin present
//   in_ready   out  adder idle and able to accept operands
//   A, B       in   WIDTH-bit operands
//   Cin        in   carry into digit 0
//   out_valid  out  SUM/Cout hold a completed result
//   out_ready  in   consumer takes the result
//   SUM        out  A+B+Cin mod 2^WIDTH
//   Cout       out  carry out of bit WIDTH-1
//   OVF        out  signed overflow of the sum (only with RCA_SERIAL_OVF_EN)
//
// Optional feature macro: RCA_SERIAL_OVF_EN adds the OVF output.

module rca_serial_n #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
`ifdef RCA_SERIAL_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;

  generate
    if (DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("rca_serial_n: WIDTH must be a positive integer multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                       state;
  logic [CNT_W-1:0]             cnt;
  logic                         carry;
  // Operands and sum are stored digit-indexed so the active digit is
  // selected directly by the counter.
  logic [NDIG-1:0][DIGIT-1:0]   a_reg;
  logic [NDIG-1:0][DIGIT-1:0]   b_reg;
  logic [NDIG-1:0][DIGIT-1:0]   sum_reg;

  logic [DIGIT-1:0]             a_dig;
  logic [DIGIT-1:0]             b_dig;
  logic [DIGIT:0]               dsum;
  logic                         last_dig;

  assign in_ready = (state == IDLE);
  assign SUM      = sum_reg;

  always_comb begin
    a_dig    = a_reg[cnt];
    b_dig    = b_reg[cnt];
    dsum     = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry};
    last_dig = (cnt == CNT_W'(NDIG - 1));
  end

`ifdef RCA_SERIAL_OVF_EN
  // Carry into the digit's top bit is recovered as a^b^s of that bit; XOR
  // with the digit carry-out gives the two's-complement overflow.
  logic top_ovf;
  assign top_ovf = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ dsum[DIGIT-1] ^ dsum[DIGIT];
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
`ifdef RCA_SERIAL_OVF_EN
      OVF       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= A;
            b_reg <= B;
            carry <= Cin;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_reg[cnt] <= dsum[DIGIT-1:0];
          carry        <= dsum[DIGIT];
          cnt          <= cnt + 1'b1;
          if (last_dig) begin
            Cout      <= dsum[DIGIT];
            out_valid <= 1'b1;
`ifdef RCA_SERIAL_OVF_EN
            OVF       <= top_ovf;
`endif
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
